// File: rtl/frame_row_store_pkg.sv
// rtl/frame_row_store_pkg.sv - shared geometry, widths and FSM state type for the frame row store
package frame_row_store_pkg;

    localparam int ROW_BITS      = 1280;
    localparam int ROWS          = 720;
    localparam int WORD_BITS     = 32;
    localparam int WORDS_PER_ROW = ROW_BITS / WORD_BITS;
    localparam int ROW_AW        = $clog2(ROWS);
    localparam int WCNT_W        = 6;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_t;

endpackage

// File: rtl/frame_row_store_if.sv
// rtl/frame_row_store_if.sv - word-stream input and row-fetch read port of the frame row store
interface frame_row_store_if;
    import frame_row_store_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_BITS-1:0]  in_data;
    logic                  in_sof;
    logic [ROW_AW-1:0]     fetch_addr;
    logic [ROW_BITS-1:0]   fetch_mem;

    modport master (
        output in_valid, in_data, in_sof, fetch_addr,
        input  in_ready, fetch_mem
    );

    modport slave (
        input  in_valid, in_data, in_sof, fetch_addr,
        output in_ready, fetch_mem
    );

endinterface

// File: rtl/frame_row_store_row_ram.sv
// rtl/frame_row_store_row_ram.sv - row_ram: single-write single-read row memory, registered read, out-of-range reads return zero
module row_ram
    import frame_row_store_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ROW_AW-1:0]   wr_addr,
    input  logic [ROW_BITS-1:0] wr_data,
    input  logic [ROW_AW-1:0]   rd_addr,
    output logic [ROW_BITS-1:0] rd_data
);

    localparam logic [ROW_AW:0] DEPTH = (ROW_AW+1)'(ROWS);

    logic [ROW_BITS-1:0] mem [ROWS];

    // Write port; contents are never cleared, reset only blocks the write
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port (read-first against a same-cycle write)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < DEPTH) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/frame_row_store.sv
// rtl/frame_row_store.sv - packs the word stream into rows and serves row fetches; option FRAME_ROW_STORE_WR_FWD_EN
module frame_row_store
    import frame_row_store_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    frame_row_store_if.slave   bus,
    output logic [ROW_AW-1:0]  wr_row,
    output logic               frame_done,
    output logic               sync_err
);

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_ROW - 1);
    localparam logic [ROW_AW-1:0] LAST_ROW  = ROW_AW'(ROWS - 1);

    state_t              state;
    logic                in_ready_q;
    logic [WCNT_W-1:0]   wcnt;
    logic [WCNT_W-1:0]   wsel;
    logic [ROW_BITS-1:0] row_buf;
    logic [ROW_BITS-1:0] ram_q;
    logic                accept;
    logic                wr_en;

    assign accept       = bus.in_valid && in_ready_q;
    assign bus.in_ready = in_ready_q;
    assign wr_en        = (state == COMMIT);

    // A start-of-frame beat always lands in word 0, whatever the counter says
    assign wsel = bus.in_sof ? '0 : wcnt;

    // Pack accepted words into the row buffer; stray IDLE beats are not stored
    always_ff @(posedge clk) begin
        if (rst_n && accept && (state == FILL || bus.in_sof)) begin
            for (int i = 0; i < WORDS_PER_ROW; i++) begin
                if (wsel == WCNT_W'(i)) begin
                    row_buf[i*WORD_BITS +: WORD_BITS] <= bus.in_data;
                end
            end
        end
    end

    // Framing FSM: word counting, row commit sequencing and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            wcnt       <= '0;
            wr_row     <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (bus.in_sof) begin
                            wcnt  <= WCNT_W'(1);
                            state <= FILL;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (bus.in_sof) begin
                            // Resync: drop the partial row and restart at row 0
                            sync_err <= 1'b1;
                            wr_row   <= '0;
                            wcnt     <= WCNT_W'(1);
                        end else if (wcnt == LAST_WORD) begin
                            wcnt       <= '0;
                            in_ready_q <= 1'b0;
                            state      <= COMMIT;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    in_ready_q <= 1'b1;
                    if (wr_row == LAST_ROW) begin
                        wr_row     <= '0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wr_row <= wr_row + 1'b1;
                        state  <= FILL;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    row_ram u_row_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_row),
        .wr_data (row_buf),
        .rd_addr (bus.fetch_addr),
        .rd_data (ram_q)
    );

`ifdef FRAME_ROW_STORE_WR_FWD_EN
    logic fwd_hit_q;

    // Remember a fetch of the row being committed; row_buf still holds that
    // row in the following cycle because no beat can be accepted until then
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_hit_q <= 1'b0;
        end else begin
            fwd_hit_q <= wr_en && (bus.fetch_addr == wr_row);
        end
    end

    assign bus.fetch_mem = fwd_hit_q ? row_buf : ram_q;
`else
    assign bus.fetch_mem = ram_q;
`endif

endmodule

// File: tb/tb_frame_row_store.sv
// tb/tb_frame_row_store.sv - self-checking bench for frame_row_store
module tb_frame_row_store;
    import frame_row_store_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ROW_AW-1:0] wr_row;
    logic              frame_done;
    logic              sync_err;

    always #5 clk = ~clk;

    frame_row_store_if bus();

    frame_row_store dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .wr_row     (wr_row),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    typedef struct {
        logic [ROW_AW-1:0]   addr;
        logic [ROW_BITS-1:0] exp;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    int se_cnt = 0;
    logic [ROW_BITS-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_done) fd_cnt++;
            if (sync_err)   se_cnt++;
        end
    end

    function automatic logic [31:0] pat(int r, int w, logic [15:0] salt);
        return {10'(r), 6'(w), salt};
    endfunction

    function automatic logic [ROW_BITS-1:0] row_pat(int r, logic [15:0] salt);
        logic [ROW_BITS-1:0] v;
        for (int w = 0; w < WORDS_PER_ROW; w++) v[w*32 +: 32] = pat(r, w, salt);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [ROW_BITS-1:0] act, input logic [ROW_BITS-1:0] exp);
        int bad_w;
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            bad_w = 0;
            for (int w = WORDS_PER_ROW - 1; w >= 0; w--) if (act[w*32 +: 32] !== exp[w*32 +: 32]) bad_w = w;
            $display("FAIL %s: word %0d got %h expected %h", name, bad_w, act[bad_w*32 +: 32], exp[bad_w*32 +: 32]);
        end
    endtask

    task automatic read_check(input string name, input logic [ROW_AW-1:0] addr, input logic [ROW_BITS-1:0] exp);
        bus.fetch_addr = addr;
        exp_q.push_back(exp);
        tick();
        chk_row(name, bus.fetch_mem, exp_q.pop_front());
    endtask

    task automatic send_beat(input logic [31:0] d, input logic sof, input int gap, output int stalls);
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        stalls = 0;
        while (bus.in_ready !== 1'b1 && stalls < 50) begin
            tick();
            stalls++;
        end
        if (bus.in_ready !== 1'b1) chk_int("beat_accept_timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        int   st, bad, fd0, se0;
        logic [ROW_BITS-1:0] rdw_exp;

        tbl[0] = '{10'd0,    row_pat(0,   16'hA5A5)};
        tbl[1] = '{10'd3,    row_pat(3,   16'hA5A5)};
        tbl[2] = '{10'd719,  row_pat(719, 16'hA5A5)};
        tbl[3] = '{10'd400,  row_pat(400, 16'hA5A5)};
        tbl[4] = '{10'd720,  '0};
        tbl[5] = '{10'd1023, '0};

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_sof     = 1'b0;
        bus.fetch_addr = 10'd720;

        // Reset and idle read
        repeat (3) tick();
        chk_int("ready_in_reset", int'(bus.in_ready), 0);
        chk_row("fetch_in_reset", bus.fetch_mem, '0);
        rst_n = 1'b1;
        tick();
        chk_int("ready_after_release", int'(bus.in_ready), 1);
        chk_int("wr_row_reset", int'(wr_row), 0);
        chk_int("frame_done_reset", int'(frame_done), 0);
        chk_int("sync_err_reset", int'(sync_err), 0);
        read_check("idle_read_oob", 10'd720, '0);

        // Full frame at full rate
        fd0 = fd_cnt;
        bad = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int w = 0; w < WORDS_PER_ROW; w++) begin
                send_beat(pat(r, w, 16'hA5A5), (r == 0 && w == 0), 0, st);
                if (st != ((w == 0 && r > 0) ? 1 : 0)) bad++;
            end
        end
        chk_int("commit_stall_pattern", bad, 0);
        chk_int("final_commit_ready", int'(bus.in_ready), 0);
        tick();
        chk_int("frame_done_pulse", int'(frame_done), 1);
        chk_int("wr_row_wrap", int'(wr_row), 0);
        tick();
        chk_int("frame_done_once", fd_cnt - fd0, 1);
        chk_int("frame_done_low", int'(frame_done), 0);
        for (int i = 0; i < 6; i++) read_check($sformatf("frame_row_%0d", tbl[i].addr), tbl[i].addr, tbl[i].exp);

        // Backpressure and gaps
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < WORDS_PER_ROW; w++)
                send_beat(pat(r, w, 16'h1111), (r == 0 && w == 0), $urandom_range(0, 3), st);
            chk_int($sformatf("bp_wr_row_in_commit_%0d", r), int'(wr_row), r);
            tick();
            chk_int($sformatf("bp_wr_row_step_%0d", r), int'(wr_row), r + 1);
        end
        read_check("bp_row0", 10'd0, row_pat(0, 16'h1111));
        read_check("bp_row1", 10'd1, row_pat(1, 16'h1111));

        // Mid-row resync on word 17 of row 2
        for (int w = 0; w < 17; w++) send_beat(pat(2, w, 16'h1111), 1'b0, $urandom_range(0, 2), st);
        se0 = se_cnt;
        send_beat(pat(0, 0, 16'h2222), 1'b1, 0, st);
        chk_int("resync_sync_err", int'(sync_err), 1);
        chk_int("resync_wr_row", int'(wr_row), 0);
        for (int w = 1; w < WORDS_PER_ROW; w++) send_beat(pat(0, w, 16'h2222), 1'b0, $urandom_range(0, 2), st);
        tick();
        chk_int("resync_sync_err_once", se_cnt - se0, 1);
        chk_int("resync_wr_row_next", int'(wr_row), 1);
        read_check("resync_row0", 10'd0, row_pat(0, 16'h2222));
        read_check("resync_row1_kept", 10'd1, row_pat(1, 16'h1111));
        read_check("resync_row2_old", 10'd2, row_pat(2, 16'hA5A5));

        // Stray data in IDLE after a mid-frame reset
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk_int("rst_mid_wr_row", int'(wr_row), 0);
        se0 = se_cnt;
        for (int i = 0; i < 5; i++) send_beat(32'hDEAD_0000 + 32'(i), 1'b0, 0, st);
        tick();
        chk_int("stray_sync_err_count", se_cnt - se0, 5);
        chk_int("stray_wr_row", int'(wr_row), 0);
        read_check("stray_row0_kept", 10'd0, row_pat(0, 16'h2222));

        // Read-during-write of row 4 in its COMMIT cycle
        for (int r = 0; r < 5; r++)
            for (int w = 0; w < WORDS_PER_ROW; w++)
                send_beat(pat(r, w, 16'h3333), (r == 0 && w == 0), 0, st);
        chk_int("rdw_wr_row", int'(wr_row), 4);
        chk_int("rdw_in_commit", int'(bus.in_ready), 0);
`ifdef FRAME_ROW_STORE_WR_FWD_EN
        rdw_exp = row_pat(4, 16'h3333);
`else
        rdw_exp = row_pat(4, 16'hA5A5);
`endif
        read_check("rdw_commit_cycle", 10'd4, rdw_exp);
        read_check("rdw_after", 10'd4, row_pat(4, 16'h3333));

        // Reset landing on a COMMIT cycle must not write the row
        for (int w = 0; w < WORDS_PER_ROW; w++) send_beat(pat(5, w, 16'h3333), 1'b0, 0, st);
        chk_int("rst_commit_state", int'(bus.in_ready), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_int("rst_commit_wr_row", int'(wr_row), 0);
        chk_int("rst_commit_ready", int'(bus.in_ready), 1);
        read_check("rst_commit_row5", 10'd5, row_pat(5, 16'hA5A5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
